// File: rtl/scale_demux_pkg.sv
// Shared types for the scale_demux slice: buffer occupancy states, route select and buffer depth.
package scale_demux_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } buf_state_t;

   typedef enum logic {
      SEL_B = 1'b0,
      SEL_A = 1'b1
   } demux_sel_t;

   localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/demux_buf.sv
// Two-entry elastic buffer. Entry 0 is always the head, so head_data comes straight from a
// register and stays stable while the consumer stalls.
module demux_buf
   import scale_demux_pkg::*;
#(
   parameter int unsigned DEMUX_WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DEMUX_WIDTH-1:0] push_data,
   input  logic                   pop,
   output logic [DEMUX_WIDTH-1:0] head_data,
   output logic                   valid,
   output logic                   full
);

   buf_state_t             state_q, state_d;
   logic [DEMUX_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DEMUX_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic                   do_push;
   logic                   do_pop;

   // Occupancy and storage registers; reset drops every buffered word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
      end
   end

   // Next occupancy and storage; a push into ONE alongside a pop replaces the head in place.
   always_comb begin
      state_d = state_q;
      mem_d   = mem_q;
      do_push = push && (state_q != FULL);
      do_pop  = pop && (state_q != EMPTY);
      unique case (state_q)
         EMPTY: begin
            if (do_push) begin
               mem_d[0] = push_data;
               state_d  = ONE;
            end
         end
         ONE: begin
            if (do_push && do_pop) begin
               mem_d[0] = push_data;
            end else if (do_push) begin
               mem_d[1] = push_data;
               state_d  = FULL;
            end else if (do_pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (do_pop) begin
               mem_d[0] = mem_q[1];
               state_d  = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign head_data = mem_q[0];
   assign valid     = (state_q != EMPTY);
   assign full      = (state_q == FULL);

endmodule

// File: rtl/scale_demux.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted word to buffer A or B by in_sel_a.
// Optional feature macro SCALE_DEMUX_CNT_EN adds per-output delivered-word counters cnt_a/cnt_b.
module scale_demux
   import scale_demux_pkg::*;
#(
   parameter int unsigned DEMUX_WIDTH = 1
`ifdef SCALE_DEMUX_CNT_EN
   ,
   parameter int unsigned CNT_WIDTH = 8
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DEMUX_WIDTH-1:0] in_data,
   input  logic                   in_sel_a,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DEMUX_WIDTH-1:0] out_a_data,
   output logic                   out_a_valid,
   input  logic                   out_a_ready,
   output logic [DEMUX_WIDTH-1:0] out_b_data,
   output logic                   out_b_valid,
   input  logic                   out_b_ready
`ifdef SCALE_DEMUX_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]   cnt_a,
   output logic [CNT_WIDTH-1:0]   cnt_b
`endif
);

   demux_sel_t sel;
   logic       a_full;
   logic       b_full;
   logic       push_a;
   logic       push_b;
   logic       pop_a;
   logic       pop_b;

   // Route and ready: ready reflects only the targeted buffer, never in_valid.
   always_comb begin
      sel      = demux_sel_t'(in_sel_a);
      in_ready = (sel == SEL_A) ? ~a_full : ~b_full;
      push_a   = in_valid && in_ready && (sel == SEL_A);
      push_b   = in_valid && in_ready && (sel == SEL_B);
      pop_a    = out_a_valid && out_a_ready;
      pop_b    = out_b_valid && out_b_ready;
   end

   // An unknown select on an offered word is a producer bug.
   always_comb begin
      if (!rst && in_valid) begin
         assert (!$isunknown(in_sel_a));
      end
   end

   demux_buf #(
      .DEMUX_WIDTH (DEMUX_WIDTH)
   ) u_buf_a (
      .clk       (clk),
      .rst       (rst),
      .push      (push_a),
      .push_data (in_data),
      .pop       (pop_a),
      .head_data (out_a_data),
      .valid     (out_a_valid),
      .full      (a_full)
   );

   demux_buf #(
      .DEMUX_WIDTH (DEMUX_WIDTH)
   ) u_buf_b (
      .clk       (clk),
      .rst       (rst),
      .push      (push_b),
      .push_data (in_data),
      .pop       (pop_b),
      .head_data (out_b_data),
      .valid     (out_b_valid),
      .full      (b_full)
   );

`ifdef SCALE_DEMUX_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_a_q;
   logic [CNT_WIDTH-1:0] cnt_b_q;

   // Delivered-word counters; wrap naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         if (pop_a) cnt_a_q <= cnt_a_q + 1'b1;
         if (pop_b) cnt_b_q <= cnt_b_q + 1'b1;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_scale_demux.sv
// Self-checking bench for scale_demux (DEMUX_WIDTH=8). A queue-based model of the two outputs is
// compared against the DUT every negative clock edge; directed steps pin literal expectations.
// Counter checks are active when SCALE_DEMUX_CNT_EN is defined.
module tb_scale_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_sel_a;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_a_data;
   logic       out_a_valid;
   logic       out_a_ready;
   logic [7:0] out_b_data;
   logic       out_b_valid;
   logic       out_b_ready;
`ifdef SCALE_DEMUX_CNT_EN
   logic [7:0] cnt_a;
   logic [7:0] cnt_b;
`endif

   scale_demux #(
      .DEMUX_WIDTH (8)
`ifdef SCALE_DEMUX_CNT_EN
      ,
      .CNT_WIDTH   (8)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_sel_a    (in_sel_a),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready)
`ifdef SCALE_DEMUX_CNT_EN
      ,
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int dut_stalls = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each output is a FIFO of at most two words.
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] mcnt_a = 8'd0;
   logic [7:0] mcnt_b = 8'd0;
   bit         last_acc = 1'b0;

   always @(posedge rst) begin
      qa.delete();
      qb.delete();
      mcnt_a = 8'd0;
      mcnt_b = 8'd0;
      last_acc = 1'b0;
   end

   always @(posedge clk) begin
      if (!rst) begin
         bit pa, pb, rdy;
         pa  = (qa.size() > 0) && out_a_ready;
         pb  = (qb.size() > 0) && out_b_ready;
         rdy = in_sel_a ? (qa.size() < 2) : (qb.size() < 2);
         last_acc = in_valid && rdy;
         if (pa) begin
            void'(qa.pop_front());
            mcnt_a = mcnt_a + 8'd1;
         end
         if (pb) begin
            void'(qb.pop_front());
            mcnt_b = mcnt_b + 8'd1;
         end
         if (last_acc) begin
            if (in_sel_a) qa.push_back(in_data);
            else qb.push_back(in_data);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      bit rdy;
      rdy = in_sel_a ? (qa.size() < 2) : (qb.size() < 2);
      chk("out_a_valid", 32'(out_a_valid), 32'(qa.size() > 0));
      chk("out_b_valid", 32'(out_b_valid), 32'(qb.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(rdy));
      if (qa.size() > 0) chk("out_a_data", 32'(out_a_data), 32'(qa[0]));
      if (qb.size() > 0) chk("out_b_data", 32'(out_b_data), 32'(qb[0]));
`ifdef SCALE_DEMUX_CNT_EN
      chk("cnt_a", 32'(cnt_a), 32'(mcnt_a));
      chk("cnt_b", 32'(cnt_b), 32'(mcnt_b));
`endif
      if (!rst && in_valid && !in_ready) dut_stalls++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_data = 8'h00;
      in_sel_a = 1'b0;
      in_valid = 1'b0;
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      #12;
      chk("rst_a_valid", 32'(out_a_valid), 32'd0);
      chk("rst_b_valid", 32'(out_b_valid), 32'd0);
      chk("rst_a_data", 32'(out_a_data), 32'd0);
      chk("rst_b_data", 32'(out_b_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SCALE_DEMUX_CNT_EN
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);
`endif
      step();
      rst = 1'b0;

      // Single word to A, one cycle latency.
      step();
      in_valid = 1'b1; in_data = 8'h11; in_sel_a = 1'b1;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_a_valid", 32'(out_a_valid), 32'd1);
      chk("t1_a_data", 32'(out_a_data), 32'h11);
      chk("t1_b_valid", 32'(out_b_valid), 32'd0);
      step();

      // Fill B while stalled, A still flows, then drain B in order.
      out_b_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; in_sel_a = 1'b0;
      step();
      in_data = 8'h02;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_b_full_ready", 32'(in_ready), 32'd0);
      in_sel_a = 1'b1;
      #1;
      chk("t2_a_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b1; in_data = 8'h03; in_sel_a = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_a_data", 32'(out_a_data), 32'h03);
      step();
      out_b_ready = 1'b1;
      @(negedge clk);
      chk("t2_b_first", 32'(out_b_data), 32'h01);
      step();
      @(negedge clk);
      chk("t2_b_second", 32'(out_b_data), 32'h02);
      step();
      @(negedge clk);
      chk("t2_b_empty", 32'(out_b_valid), 32'd0);

      // Push and pop on B while in ONE keeps occupancy.
      step();
      out_b_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h05; in_sel_a = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_data = 8'h06; in_sel_a = 1'b0; out_b_ready = 1'b1;
      @(negedge clk);
      chk("t3_head_05", 32'(out_b_data), 32'h05);
      step();
      in_valid = 1'b0; out_b_ready = 1'b0;
      @(negedge clk);
      chk("t3_head_06", 32'(out_b_data), 32'h06);
      chk("t3_still_one", 32'(in_ready), 32'd1);
      step();
      out_b_ready = 1'b1;
      step();
      step();

      // Alternating select at full rate, no stalls allowed.
      dut_stalls = 0;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_sel_a = i[0];
         in_data = 8'($urandom);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("t4_stalls", 32'(dut_stalls), 32'd0);

      // Random traffic with random back-pressure; stalled words are held.
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel_a = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
         end
         out_a_ready = ($urandom_range(0, 3) != 0);
         out_b_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      in_valid = 1'b0;

      // Fill both buffers, then reset between edges.
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      step();
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sel_a = i[0]; in_data = 8'hA0 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t5_a_valid_async", 32'(out_a_valid), 32'd0);
      chk("t5_b_valid_async", 32'(out_b_valid), 32'd0);
      chk("t5_ready_async", 32'(in_ready), 32'd1);
      #10;
      rst = 1'b0;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      chk("t5_no_stale_a", 32'(out_a_valid), 32'd0);
      chk("t5_no_stale_b", 32'(out_b_valid), 32'd0);

`ifdef SCALE_DEMUX_CNT_EN
      // 257 deliveries on A wrap the counter to 1.
      step();
      for (int i = 0; i < 257; i++) begin
         in_valid = 1'b1; in_sel_a = 1'b1; in_data = 8'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("t6_cnt_a_wrap", 32'(cnt_a), 32'd1);
      chk("t6_cnt_b_zero", 32'(cnt_b), 32'd0);
`endif

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
